// File: rtl/sort8.sv
// Eight-word unsigned sorter: captures din on request, runs eight odd-even
// transposition phases (one per clock) and presents the result with a fin handshake.
module sort8 #(
  parameter int W = 32
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           req,
  output logic           fin,
  input  logic [8*W-1:0] din,
  output logic [8*W-1:0] dout
);

  typedef enum logic [1:0] {
    IDLE,
    SORT,
    DONE
  } stateT;

  stateT          state;
  stateT          nextState;
  logic [2:0]     phase;
  logic [W-1:0]   work    [8];
  logic [W-1:0]   stepped [8];
  logic [8*W-1:0] steppedFlat;
  logic           oddPhase;

  assign oddPhase = phase[0];

  // One transposition phase; pairs within a phase never overlap, so a single pass is safe.
  always_comb begin
    for (int i = 0; i < 8; i++) begin
      stepped[i] = work[i];
    end
    for (int i = 0; i < 7; i++) begin
      if ((((i % 2) == 1) == oddPhase) && (work[i] > work[i+1])) begin
        stepped[i]   = work[i+1];
        stepped[i+1] = work[i];
      end
    end
  end

  always_comb begin
    steppedFlat = '0;
    for (int k = 0; k < 8; k++) begin
      steppedFlat[W*(7-k) +: W] = stepped[k];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= nextState;
    end
  end

  always_comb begin
    nextState = state;
    case (state)
      IDLE: if (req) nextState = SORT;
      SORT: begin
        if (!req) begin
          nextState = IDLE;
        end else if (phase == 3'd7) begin
          nextState = DONE;
        end
      end
      DONE: if (!req) nextState = IDLE;
      default: nextState = IDLE;
    endcase
  end

  // dout is only written on the phase-7 edge, so aborts and idling leave the last result visible.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fin   <= 1'b0;
      phase <= '0;
      dout  <= '0;
      for (int k = 0; k < 8; k++) begin
        work[k] <= '0;
      end
    end else begin
      fin <= (nextState == DONE);
      case (state)
        IDLE: begin
          if (req) begin
            phase <= '0;
            for (int k = 0; k < 8; k++) begin
              work[k] <= din[W*(7-k) +: W];
            end
          end
        end
        SORT: begin
          if (req) begin
            phase <= phase + 3'd1;
            for (int k = 0; k < 8; k++) begin
              work[k] <= stepped[k];
            end
            if (phase == 3'd7) begin
              dout <= steppedFlat;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_sort8.sv
// Directed bench for sort8: hand-computed sort results, handshake timing, abort and reset.
module tb_sort8;

  logic         clk;
  logic         rst_n;
  logic         req;
  logic         fin;
  logic [255:0] din;
  logic [255:0] dout;

  int cmpCount  = 0;
  int failCount = 0;

  sort8 #(.W(32)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .req  (req),
    .fin  (fin),
    .din  (din),
    .dout (dout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [255:0] pack8(input logic [31:0] e0, input logic [31:0] e1,
                                         input logic [31:0] e2, input logic [31:0] e3,
                                         input logic [31:0] e4, input logic [31:0] e5,
                                         input logic [31:0] e6, input logic [31:0] e7);
    return {e0, e1, e2, e3, e4, e5, e6, e7};
  endfunction

  // Drives a new request so that the next rising edge is the capture edge.
  task automatic applyStimulus(input logic [255:0] d);
    @(negedge clk);
    din = d;
    req = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b1;
    req   = 1'b0;
    din   = '0;
    #2 rst_n = 1'b0;
    #10;
    cmpCount++;
    if (fin !== 1'b0) begin
      failCount++;
      $display("[TB] FAIL reset_fin: got %b expected 0", fin);
    end
    cmpCount++;
    if (dout !== '0) begin
      failCount++;
      $display("[TB] FAIL reset_dout: got %h expected 0", dout);
    end
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    cmpCount++;
    if (fin !== 1'b0) begin
      failCount++;
      $display("[TB] FAIL idle_fin: got %b expected 0", fin);
    end
  endtask

  task automatic test_unsorted();
    logic [255:0] expected;
    expected = pack8(32'h00, 32'h10, 32'h20, 32'h30, 32'h40, 32'h50, 32'h60, 32'h70);
    applyStimulus(pack8(32'h30, 32'h10, 32'h70, 32'h00, 32'h50, 32'h20, 32'h60, 32'h40));
    for (int e = 1; e <= 8; e++) begin
      @(negedge clk);
      cmpCount++;
      if (fin !== 1'b0) begin
        failCount++;
        $display("[TB] FAIL unsorted_early_fin edge %0d: got %b expected 0", e, fin);
      end
    end
    @(negedge clk);
    cmpCount++;
    if (fin !== 1'b1) begin
      failCount++;
      $display("[TB] FAIL unsorted_fin: got %b expected 1", fin);
    end
    cmpCount++;
    if (dout !== expected) begin
      failCount++;
      $display("[TB] FAIL unsorted_dout: got %h expected %h", dout, expected);
    end
    req = 1'b0;
    @(negedge clk);
    cmpCount++;
    if (fin !== 1'b0) begin
      failCount++;
      $display("[TB] FAIL unsorted_release_fin: got %b expected 0", fin);
    end
  endtask

  task automatic test_extremes();
    logic [255:0] expected;
    expected = pack8(32'd2, 32'd3, 32'd4, 32'd5, 32'd6, 32'd7, 32'h80000000, 32'hFFFFFFFF);
    applyStimulus(pack8(32'hFFFFFFFF, 32'd7, 32'd6, 32'd5, 32'd4, 32'd3, 32'd2, 32'h80000000));
    repeat (9) @(negedge clk);
    cmpCount++;
    if ((fin !== 1'b1) || (dout !== expected)) begin
      failCount++;
      $display("[TB] FAIL extremes: got fin=%b dout=%h expected fin=1 dout=%h", fin, dout, expected);
    end
    req = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_duplicates();
    logic [255:0] expected;
    expected = pack8(32'd0, 32'd1, 32'd1, 32'd5, 32'd5, 32'd5, 32'd9, 32'd9);
    applyStimulus(pack8(32'd5, 32'd5, 32'd1, 32'd5, 32'd1, 32'd9, 32'd9, 32'd0));
    repeat (9) @(negedge clk);
    cmpCount++;
    if ((fin !== 1'b1) || (dout !== expected)) begin
      failCount++;
      $display("[TB] FAIL duplicates: got fin=%b dout=%h expected fin=1 dout=%h", fin, dout, expected);
    end
  endtask

  // Entered with the duplicates result held in DONE and req still high.
  task automatic test_handshake();
    logic [255:0] held;
    logic [255:0] expected;
    held     = pack8(32'd0, 32'd1, 32'd1, 32'd5, 32'd5, 32'd5, 32'd9, 32'd9);
    expected = pack8(32'd1, 32'd2, 32'd3, 32'd4, 32'd6, 32'd7, 32'd8, 32'd9);
    din = pack8(32'd9, 32'd3, 32'd8, 32'd1, 32'd7, 32'd2, 32'd6, 32'd4);
    repeat (3) @(negedge clk);
    cmpCount++;
    if ((fin !== 1'b1) || (dout !== held)) begin
      failCount++;
      $display("[TB] FAIL done_hold: got fin=%b dout=%h expected fin=1 dout=%h", fin, dout, held);
    end
    req = 1'b0;
    @(negedge clk);
    cmpCount++;
    if ((fin !== 1'b0) || (dout !== held)) begin
      failCount++;
      $display("[TB] FAIL release: got fin=%b dout=%h expected fin=0 dout=%h", fin, dout, held);
    end
    applyStimulus(pack8(32'd9, 32'd3, 32'd8, 32'd1, 32'd7, 32'd2, 32'd6, 32'd4));
    repeat (8) @(negedge clk);
    cmpCount++;
    if (fin !== 1'b0) begin
      failCount++;
      $display("[TB] FAIL resort_early_fin: got %b expected 0", fin);
    end
    @(negedge clk);
    cmpCount++;
    if ((fin !== 1'b1) || (dout !== expected)) begin
      failCount++;
      $display("[TB] FAIL resort: got fin=%b dout=%h expected fin=1 dout=%h", fin, dout, expected);
    end
    req = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_abort();
    logic [255:0] prior;
    logic [255:0] expected;
    prior    = pack8(32'd1, 32'd2, 32'd3, 32'd4, 32'd6, 32'd7, 32'd8, 32'd9);
    expected = pack8(32'd1, 32'd2, 32'd3, 32'd4, 32'd5, 32'd6, 32'd7, 32'd8);
    applyStimulus(pack8(32'd8, 32'd7, 32'd6, 32'd5, 32'd4, 32'd3, 32'd2, 32'd1));
    repeat (4) @(negedge clk);
    req = 1'b0;
    repeat (10) @(negedge clk);
    cmpCount++;
    if ((fin !== 1'b0) || (dout !== prior)) begin
      failCount++;
      $display("[TB] FAIL abort: got fin=%b dout=%h expected fin=0 dout=%h", fin, dout, prior);
    end
    applyStimulus(pack8(32'd8, 32'd7, 32'd6, 32'd5, 32'd4, 32'd3, 32'd2, 32'd1));
    repeat (8) @(negedge clk);
    cmpCount++;
    if (fin !== 1'b0) begin
      failCount++;
      $display("[TB] FAIL abort_restart_early_fin: got %b expected 0", fin);
    end
    @(negedge clk);
    cmpCount++;
    if ((fin !== 1'b1) || (dout !== expected)) begin
      failCount++;
      $display("[TB] FAIL abort_restart: got fin=%b dout=%h expected fin=1 dout=%h", fin, dout, expected);
    end
    req = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_din_change();
    logic [255:0] expected;
    expected = pack8(32'd0, 32'd25, 32'd50, 32'd75, 32'd100, 32'd125, 32'd150, 32'd200);
    applyStimulus(pack8(32'd100, 32'd50, 32'd25, 32'd75, 32'd0, 32'd200, 32'd150, 32'd125));
    @(negedge clk);
    din = {8{32'hDEAD}};
    repeat (4) @(negedge clk);
    din = pack8(32'd1, 32'd1, 32'd1, 32'd1, 32'd1, 32'd1, 32'd1, 32'd1);
    repeat (4) @(negedge clk);
    cmpCount++;
    if ((fin !== 1'b1) || (dout !== expected)) begin
      failCount++;
      $display("[TB] FAIL din_change: got fin=%b dout=%h expected fin=1 dout=%h", fin, dout, expected);
    end
    req = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_reset_mid_sort();
    logic [255:0] expected;
    int           earlyFins;
    expected  = pack8(32'd10, 32'd20, 32'd30, 32'd40, 32'd50, 32'd60, 32'd70, 32'd80);
    earlyFins = 0;
    applyStimulus(pack8(32'd3, 32'd1, 32'd2, 32'd7, 32'd6, 32'd5, 32'd4, 32'd0));
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b0;
    req = 1'b0;
    #1;
    cmpCount++;
    if ((fin !== 1'b0) || (dout !== '0)) begin
      failCount++;
      $display("[TB] FAIL reset_mid_sort: got fin=%b dout=%h expected fin=0 dout=0", fin, dout);
    end
    @(negedge clk);
    rst_n = 1'b1;
    for (int e = 0; e < 12; e++) begin
      @(negedge clk);
      if (fin !== 1'b0) earlyFins++;
    end
    cmpCount++;
    if ((earlyFins !== 0) || (dout !== '0)) begin
      failCount++;
      $display("[TB] FAIL post_reset_idle: got fin-high edges=%0d dout=%h expected 0 and 0", earlyFins, dout);
    end
    applyStimulus(pack8(32'd40, 32'd30, 32'd20, 32'd10, 32'd80, 32'd70, 32'd60, 32'd50));
    repeat (9) @(negedge clk);
    cmpCount++;
    if ((fin !== 1'b1) || (dout !== expected)) begin
      failCount++;
      $display("[TB] FAIL post_reset_sort: got fin=%b dout=%h expected fin=1 dout=%h", fin, dout, expected);
    end
    req = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_unsorted();
    test_extremes();
    test_duplicates();
    test_handshake();
    test_abort();
    test_din_change();
    test_reset_mid_sort();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmpCount, failCount);
    $finish;
  end

endmodule
